e8bit_divide: RTL and testbench
===============================

E8BIT_DIVIDE -- requirements
Module: e8bit_divide

Interface
REQ-001 SHALL have parameter DIV_RATIO, default 2: enabled clock edges per count increment; legal range 1..256.
REQ-002 SHALL have parameter WIDTH, default 8: count width; fixed at 8 for this block.
REQ-003 SHALL have port clock  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1: count-enable qualifier, sampled on the rising edge of clock.
REQ-006 SHALL have port count_out  output  8: registered divided count value.
REQ-007 SHALL have port tick  output  1: registered one-cycle pulse marking each prescaler terminal event.

Function
REQ-008 SHALL contain an internal prescaler counter of ceil(log2(DIV_RATIO)) bits, minimum 1 bit, counting 0..DIV_RATIO-1.
REQ-009 SHALL, on an edge with enable=1 and the prescaler below DIV_RATIO-1, increment the prescaler and hold count_out.
REQ-010 SHALL, on an edge with enable=1 and the prescaler equal to DIV_RATIO-1, clear the prescaler to 0 and increment count_out by 1.
REQ-011 SHALL, on an edge with enable=0, hold both prescaler and count_out, preserving prescaler phase across enable gaps.
REQ-012 SHALL wrap count_out from 255 to 0 modulo 2^8, unless the configuration macro below is defined.
REQ-013 SHALL drive tick=1 for exactly the cycle following an edge that hit the terminal condition in REQ-010, and tick=0 otherwise.
REQ-014 SHALL, with DIV_RATIO=1, increment count_out on every enabled edge and hold tick high while enable stays high.
REQ-015 SHALL give reset priority over enable when both are high on the same edge.
REQ-016 SHALL give latency enable-edge-to-count_out change of exactly DIV_RATIO enabled edges from the reset state.

Reset
REQ-017 SHALL, on a rising edge with reset=1, set count_out=8'h00, tick=0 and prescaler=0.
REQ-018 SHALL discard any partial prescaler progress when reset is asserted mid-operation.
REQ-019 SHALL leave outputs undefined before the first reset edge; no initial values are required.

Configuration
REQ-020 SHALL, when macro E8BIT_DIVIDE_SATURATE_EN is defined, hold count_out at 8'hFF instead of wrapping, with the prescaler and tick continuing to operate.
REQ-021 SHALL, when E8BIT_DIVIDE_SATURATE_EN is undefined, wrap as in REQ-012; the port list is identical in both builds.

Structure
REQ-022 SHALL place COUNT_WIDTH=8, COUNT_MAX=8'hFF and the default DIV_RATIO constant in shared package e8bit_divide_pkg.
REQ-023 SHALL implement the prescaler as sub-module e8bit_divide_prescaler (inputs: clock, reset, enable; output: terminal strobe); the top level holds count_out and tick.

Verification
REQ-024 SHALL cover the following directed scenario: clock period 10, reset high across one edge, enable high for 10 edges (DIV_RATIO=2) -> count_out steps 0,0,1,1,2,...,5 and ends at 8'h05, then holds after enable drops.
REQ-025 SHALL cover the following directed scenario: enable toggled 1,0,1 with DIV_RATIO=2 -> count_out increments on the 2nd enabled edge, not the 2nd clock edge, because phase is preserved.
REQ-026 SHALL cover the following directed scenario: reset asserted with prescaler=1 and count_out=8'h03 -> next edge gives count_out=0 and tick=0, then 2 further enabled edges are needed to reach 1.
REQ-027 SHALL cover the following directed scenario: 512 enabled edges at DIV_RATIO=2 -> count_out returns to 8'h00 in the wrap build, or stays at 8'hFF in the saturate build.
REQ-028 SHALL cover the following directed scenario: DIV_RATIO=1 with continuous enable -> count_out increments every edge and tick stays high.
REQ-029 SHALL cover the following directed scenario: reset and enable both high -> count_out=0 with no increment.

Source files
------------

// File: rtl/e8bit_divide_pkg.sv
`default_nettype none
// ============================================================================
// Module      : e8bit_divide_pkg
// Description : Shared constants and helpers for the e8bit_divide block.
// Revision    : 1.0 - initial release
// ============================================================================
package e8bit_divide_pkg;

  localparam int                     COUNT_WIDTH       = 8;
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX         = 8'hFF;
  localparam int                     DEFAULT_DIV_RATIO = 2;

  // Prescaler width: ceil(log2(ratio)), never less than one bit so a
  // ratio of 1 still yields a legal (always-zero) register.
  function automatic int presc_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/e8bit_divide_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : e8bit_divide_prescaler
// Description : Enable-qualified modulo-DIV_RATIO prescaler. Raises the
//               combinational terminal strobe on an enabled cycle in which
//               the counter sits at DIV_RATIO-1; the counter only moves on
//               enabled cycles so phase survives enable gaps.
// Revision    : 1.0 - initial release
// ============================================================================
module e8bit_divide_prescaler
  import e8bit_divide_pkg::*;
#(
  parameter int DIV_RATIO = DEFAULT_DIV_RATIO
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic terminal
);

  localparam int           PW   = presc_width(DIV_RATIO);
  localparam logic [PW-1:0] LAST = PW'(DIV_RATIO - 1);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          at_last;

  // Next prescaler value: advance on enable, wrap to zero after LAST.
  // With DIV_RATIO=1 LAST is zero, so the counter stays at zero and every
  // enabled cycle is terminal.
  always_comb begin
    presc_d = presc_q;
    at_last = (presc_q == LAST);
    if (enable) begin
      presc_d = at_last ? '0 : presc_q + PW'(1);
    end
  end

  // Prescaler register; reset discards any partial progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign terminal = enable && at_last;

endmodule
`default_nettype wire

// File: rtl/e8bit_divide.sv
`default_nettype none
// ============================================================================
// Module      : e8bit_divide
// Description : Enable-qualified clock-edge divider. count_out advances by
//               one every DIV_RATIO enabled edges; tick pulses for the cycle
//               following each prescaler terminal event.
//               Build option: define E8BIT_DIVIDE_SATURATE_EN to make
//               count_out stick at 8'hFF instead of wrapping to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module e8bit_divide
  import e8bit_divide_pkg::*;
#(
  parameter int DIV_RATIO = DEFAULT_DIV_RATIO,
  parameter int WIDTH     = COUNT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] count_out,
  output logic             tick
);

  logic             terminal;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tick_q;
  logic             tick_d;

  e8bit_divide_prescaler #(
    .DIV_RATIO (DIV_RATIO)
  ) u_prescaler (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .terminal (terminal)
  );

  // Count and tick next-state: step the count on each terminal event,
  // either wrapping or saturating at the top depending on the build.
  always_comb begin
    count_d = count_q;
    tick_d  = terminal;
    if (terminal) begin
`ifdef E8BIT_DIVIDE_SATURATE_EN
      if (count_q != WIDTH'(COUNT_MAX)) begin
        count_d = count_q + WIDTH'(1);
      end
`else
      count_d = count_q + WIDTH'(1);
`endif
    end
  end

  // Output registers; reset has priority over enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign count_out = count_q;
  assign tick      = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_e8bit_divide.sv
`default_nettype none
// ============================================================================
// Module      : tb_e8bit_divide
// Description : Scoreboard bench for e8bit_divide with DIV_RATIO=2 and
//               DIV_RATIO=1 instances. Honors E8BIT_DIVIDE_SATURATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_e8bit_divide;

  typedef struct {
    logic [7:0] cnt;
    logic       tk;
    int         id;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       rst1 = 1'b1;
  logic       en1  = 1'b0;
  logic [7:0] cnt2;
  logic       tk2;
  logic [7:0] cnt1;
  logic       tk1;

  exp_t q2[$];
  exp_t q1[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   vid   = 0;

  always #5 clk = ~clk;

  e8bit_divide #(.DIV_RATIO(2), .WIDTH(8)) dut (
    .clock     (clk),
    .reset     (rst),
    .enable    (en),
    .count_out (cnt2),
    .tick      (tk2)
  );

  e8bit_divide #(.DIV_RATIO(1), .WIDTH(8)) dut1 (
    .clock     (clk),
    .reset     (rst1),
    .enable    (en1),
    .count_out (cnt1),
    .tick      (tk1)
  );

  // Drive one edge on the DIV_RATIO=2 instance and queue what it must show.
  task automatic step(input logic r, input logic e, input logic [7:0] c, input logic t);
    exp_t x;
    @(negedge clk);
    rst = r;
    en  = e;
    x.cnt = c; x.tk = t; x.id = vid;
    vid++;
    q2.push_back(x);
  endtask

  // Same for the DIV_RATIO=1 instance.
  task automatic step1(input logic r, input logic e, input logic [7:0] c, input logic t);
    exp_t x;
    @(negedge clk);
    rst1 = r;
    en1  = e;
    x.cnt = c; x.tk = t; x.id = vid;
    vid++;
    q1.push_back(x);
  endtask

  // Monitor: after each rising edge, check any pending expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (q2.size() > 0) begin
        x = q2.pop_front();
        n_vec++;
        if (cnt2 !== x.cnt || tk2 !== x.tk) begin
          n_err++;
          $display("FAIL div2 vec%0d: got count_out=%h tick=%b, expected count_out=%h tick=%b",
                   x.id, cnt2, tk2, x.cnt, x.tk);
        end
      end
      if (q1.size() > 0) begin
        x = q1.pop_front();
        n_vec++;
        if (cnt1 !== x.cnt || tk1 !== x.tk) begin
          n_err++;
          $display("FAIL div1 vec%0d: got count_out=%h tick=%b, expected count_out=%h tick=%b",
                   x.id, cnt1, tk1, x.cnt, x.tk);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] ec;
    // Scenario: reset then 10 enabled edges, then hold.
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h00, 0);
    step(0, 1, 8'h01, 1);
    step(0, 1, 8'h01, 0);
    step(0, 1, 8'h02, 1);
    step(0, 1, 8'h02, 0);
    step(0, 1, 8'h03, 1);
    step(0, 1, 8'h03, 0);
    step(0, 1, 8'h04, 1);
    step(0, 1, 8'h04, 0);
    step(0, 1, 8'h05, 1);
    step(0, 0, 8'h05, 0);
    step(0, 0, 8'h05, 0);

    // Scenario: enable 1,0,1 keeps prescaler phase.
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    step(0, 1, 8'h01, 1);

    // Scenario: reset mid-operation with prescaler=1, count=3.
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h00, 0);
    step(0, 1, 8'h01, 1);
    step(0, 1, 8'h01, 0);
    step(0, 1, 8'h02, 1);
    step(0, 1, 8'h02, 0);
    step(0, 1, 8'h03, 1);
    step(0, 1, 8'h03, 0);
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h00, 0);
    step(0, 1, 8'h01, 1);

    // Scenario: reset and enable together, with prescaler mid-phase.
    step(0, 1, 8'h01, 0);
    step(1, 1, 8'h00, 0);
    step(0, 1, 8'h00, 0);
    step(0, 1, 8'h01, 1);

    // Scenario: 512 enabled edges, wrap or saturate.
    step(1, 0, 8'h00, 0);
    for (int i = 1; i <= 512; i++) begin
`ifdef E8BIT_DIVIDE_SATURATE_EN
      ec = (i / 2 > 255) ? 8'hFF : 8'(i / 2);
`else
      ec = 8'(i / 2);
`endif
      step(0, 1, ec, (i % 2) == 0);
    end
`ifdef E8BIT_DIVIDE_SATURATE_EN
    step(0, 0, 8'hFF, 0);
`else
    step(0, 0, 8'h00, 0);
`endif

    // Scenario: DIV_RATIO=1, continuous enable.
    step1(1, 0, 8'h00, 0);
    step1(0, 1, 8'h01, 1);
    step1(0, 1, 8'h02, 1);
    step1(0, 1, 8'h03, 1);
    step1(0, 1, 8'h04, 1);
    step1(0, 1, 8'h05, 1);
    step1(0, 0, 8'h05, 0);
    step1(1, 1, 8'h00, 0);

    // Drain: allow a bounded number of edges for the monitor to catch up.
    for (int i = 0; i < 5 && (q2.size() > 0 || q1.size() > 0); i++) begin
      @(posedge clk);
      #3;
    end
    if (q2.size() > 0 || q1.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", q2.size() + q1.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
